// File: rtl/key_pkg.sv
// Shared definitions for the multi-channel key debouncer:
// repeat FSM encoding, key polarity and a small sizing helper.
package key_pkg;

    // Per-channel auto-repeat state.
    typedef enum logic [1:0] {
        RELEASED = 2'd0,
        HELD     = 2'd1,
        REPEAT   = 2'd2
    } rep_state_e;

    // Internal meaning of a debounced level of 1.
    localparam logic KEY_PRESSED = 1'b1;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_channel.sv
// One debounce channel: stability counter, debounced level,
// press/release pulses and the auto-repeat FSM.
module key_channel
    import key_pkg::*;
#(
    parameter int STABLE_CNT  = 3,
    parameter int REPEAT_DLY  = 50,
    parameter int REPEAT_RATE = 10
) (
    input  logic clk,
    input  logic clr_n,
    input  logic tick_i,
    input  logic sample_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic repeat_o
);

    localparam int SW   = $clog2(STABLE_CNT + 1);
    localparam int RMAX = max_int(REPEAT_DLY, REPEAT_RATE);
    localparam int RW   = $clog2(RMAX + 1);

    rep_state_e    state_q, state_d;
    logic [SW-1:0] stab_q, stab_d, stab_inc;
    logic [RW-1:0] rcnt_q, rcnt_d, rcnt_inc;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          rel_q, rel_d;
    logic          rep_q, rep_d;
    logic          acc_press, acc_rel;

    assign stab_inc = stab_q + SW'(1);
    assign rcnt_inc = rcnt_q + RW'(1);

    // Debounce: count disagreeing ticks, toggle the level on a full run.
    always_comb begin
        stab_d    = stab_q;
        level_d   = level_q;
        press_d   = 1'b0;
        rel_d     = 1'b0;
        acc_press = 1'b0;
        acc_rel   = 1'b0;
        if (tick_i) begin
            if (sample_i == level_q) begin
                stab_d = '0;
            end else if (stab_inc == SW'(STABLE_CNT)) begin
                stab_d  = '0;
                level_d = ~level_q;
                if (~level_q == KEY_PRESSED) begin
                    press_d   = 1'b1;
                    acc_press = 1'b1;
                end else begin
                    rel_d   = 1'b1;
                    acc_rel = 1'b1;
                end
            end else begin
                stab_d = stab_inc;
            end
        end
    end

    // Repeat FSM: a release always wins over a due repeat pulse.
    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        rep_d   = 1'b0;
        unique case (state_q)
            RELEASED: begin
                if (acc_press) begin
                    state_d = HELD;
                    rcnt_d  = '0;
                end
            end
            HELD: begin
                if (acc_rel) begin
                    state_d = RELEASED;
                    rcnt_d  = '0;
                end else if (tick_i && (REPEAT_DLY != 0)) begin
                    if (rcnt_inc == RW'(REPEAT_DLY)) begin
                        rep_d   = 1'b1;
                        rcnt_d  = '0;
                        state_d = REPEAT;
                    end else begin
                        rcnt_d = rcnt_inc;
                    end
                end
            end
            REPEAT: begin
                if (acc_rel) begin
                    state_d = RELEASED;
                    rcnt_d  = '0;
                end else if (tick_i) begin
                    if (rcnt_inc == RW'(REPEAT_RATE)) begin
                        rep_d  = 1'b1;
                        rcnt_d = '0;
                    end else begin
                        rcnt_d = rcnt_inc;
                    end
                end
            end
            default: begin
                state_d = RELEASED;
                rcnt_d  = '0;
            end
        endcase
    end

    // Channel state and registered outputs.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= RELEASED;
            stab_q  <= '0;
            rcnt_q  <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
            rep_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            stab_q  <= stab_d;
            rcnt_q  <= rcnt_d;
            level_q <= level_d;
            press_q <= press_d;
            rel_q   <= rel_d;
            rep_q   <= rep_d;
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = rel_q;
    assign repeat_o  = rep_q;

endmodule

// File: rtl/key_debounce_multi.sv
// Multi-key debouncer top: input synchronisers, shared sample
// tick divider and one key_channel per key.
module key_debounce_multi
    import key_pkg::*;
#(
    parameter int N_KEYS        = 4,
    parameter int CLK_DIV       = 10,
    parameter int STABLE_CNT    = 3,
    parameter int REPEAT_DLY    = 50,
    parameter int REPEAT_RATE   = 10,
    parameter int ACTIVE_LOW_IN = 0
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic [N_KEYS-1:0] key_in,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_repeat,
    output logic              key_any
);

    localparam int TW = $clog2(CLK_DIV + 1);
    localparam logic [N_KEYS-1:0] INV_MASK =
        (ACTIVE_LOW_IN != 0) ? {N_KEYS{1'b1}} : {N_KEYS{1'b0}};

    logic [TW-1:0]     div_q, div_d;
    logic              tick;
    logic [N_KEYS-1:0] sync1_q, sync2_q;

    assign tick = (div_q == TW'(CLK_DIV - 1));

    // Divider wraps at CLK_DIV-1 so tick is a one-cycle enable.
    always_comb begin
        div_d = div_q + TW'(1);
        if (tick) begin
            div_d = '0;
        end
    end

    // Tick counter and 2-FF synchronisers (polarity fixed up front).
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            div_q   <= '0;
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            div_q   <= div_d;
            sync1_q <= key_in ^ INV_MASK;
            sync2_q <= sync1_q;
        end
    end

    for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
        key_channel #(
            .STABLE_CNT (STABLE_CNT),
            .REPEAT_DLY (REPEAT_DLY),
            .REPEAT_RATE(REPEAT_RATE)
        ) u_ch (
            .clk      (clk),
            .clr_n    (clr_n),
            .tick_i   (tick),
            .sample_i (sync2_q[i]),
            .level_o  (key_level[i]),
            .press_o  (key_press[i]),
            .release_o(key_release[i]),
            .repeat_o (key_repeat[i])
        );
    end

    assign key_any = |key_level;

endmodule

// File: tb/tb_key_debounce_multi.sv
// Scoreboard bench for key_debounce_multi: three configurations
// driven with directed and random key activity.
module tb_key_debounce_multi;

    localparam int NK = 4;

    logic          clk = 1'b0;
    logic          clr_n;
    logic [NK-1:0] kin [3];
    logic [NK-1:0] lvl [3];
    logic [NK-1:0] prs [3];
    logic [NK-1:0] rel [3];
    logic [NK-1:0] rpt [3];
    logic          any [3];

    int checks = 0;
    int errors = 0;

    typedef struct {
        int            n;
        logic [NK-1:0] p;
        logic [NK-1:0] r;
        logic [NK-1:0] t;
        logic [NK-1:0] l;
    } ev_t;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : cfg
        localparam int DIV = (g == 2) ? 1 : 10;
        localparam int S   = (g == 2) ? 1 : 3;
        localparam int D   = (g == 1) ? 0 : ((g == 2) ? 5 : 50);
        localparam int R   = (g == 2) ? 3 : 10;
        localparam int AL  = (g == 2) ? 1 : 0;

        key_debounce_multi #(
            .N_KEYS(NK), .CLK_DIV(DIV), .STABLE_CNT(S),
            .REPEAT_DLY(D), .REPEAT_RATE(R), .ACTIVE_LOW_IN(AL)
        ) dut (
            .clk(clk), .clr_n(clr_n), .key_in(kin[g]),
            .key_level(lvl[g]), .key_press(prs[g]),
            .key_release(rel[g]), .key_repeat(rpt[g]),
            .key_any(any[g])
        );

        // Reference model state: edge count, tick count, per-key history.
        int            n;
        int            t;
        bit            s1 [NK];
        bit            s2 [NK];
        bit            ml [NK];
        int            lastref [NK];
        int            ptick [NK];
        bit            held [NK];
        ev_t           q [$];
        ev_t           e;
        logic [NK-1:0] ep, er, et, evl;
        bit            tk, acc, samp;
        int            h;

        always @(posedge clk or negedge clr_n) begin
            if (!clr_n) begin
                n = 0;
                t = 0;
                for (int k = 0; k < NK; k++) begin
                    s1[k] = 0; s2[k] = 0; ml[k] = 0;
                    lastref[k] = 0; ptick[k] = 0; held[k] = 0;
                end
                q.delete();
            end else begin
                n++;
                tk = (n % DIV) == 0;
                if (tk) t++;
                ep = '0; er = '0; et = '0;
                for (int k = 0; k < NK; k++) begin
                    samp  = s2[k];
                    s2[k] = s1[k];
                    s1[k] = (AL != 0) ? ~kin[g][k] : kin[g][k];
                    if (tk) begin
                        acc = 0;
                        if (samp == ml[k]) lastref[k] = t;
                        else if (t - lastref[k] == S) acc = 1;
                        if (acc) begin
                            lastref[k] = t;
                            ml[k] = ~ml[k];
                            if (ml[k]) begin
                                ep[k] = 1; held[k] = 1; ptick[k] = t;
                            end else begin
                                er[k] = 1; held[k] = 0;
                            end
                        end else if (held[k] && D != 0) begin
                            h = t - ptick[k];
                            if (h == D || (h > D && (h - D) % R == 0))
                                et[k] = 1;
                        end
                    end
                end
                for (int k = 0; k < NK; k++) evl[k] = ml[k];
                if ((ep | er | et) != 0)
                    q.push_back('{n, ep, er, et, evl});
            end
        end

        // Monitor: whenever the DUT pulses or an event is due, compare.
        always @(negedge clk) begin
            if (clr_n) begin
                while (q.size() > 0 && q[0].n < n) begin
                    checks++;
                    errors++;
                    $display("FAIL cfg%0d missed event n=%0d", g, q[0].n);
                    void'(q.pop_front());
                end
                if ((prs[g] | rel[g] | rpt[g]) != 0 ||
                    (q.size() > 0 && q[0].n == n)) begin
                    checks++;
                    if (q.size() == 0 || q[0].n != n) begin
                        errors++;
                        $display("FAIL cfg%0d unexpected pulse n=%0d p=%b r=%b t=%b",
                                 g, n, prs[g], rel[g], rpt[g]);
                    end else begin
                        e = q.pop_front();
                        if (e.p !== prs[g] || e.r !== rel[g] ||
                            e.t !== rpt[g] || e.l !== lvl[g] ||
                            any[g] !== (|e.l)) begin
                            errors++;
                            $display("FAIL cfg%0d event n=%0d got p=%b r=%b t=%b l=%b a=%b exp p=%b r=%b t=%b l=%b",
                                     g, n, prs[g], rel[g], rpt[g], lvl[g], any[g],
                                     e.p, e.r, e.t, e.l);
                        end
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", nm, act, exp);
        end
    endtask

    task automatic chk_rng(input string nm, input int act,
                           input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s got %0d exp %0d..%0d", nm, act, lo, hi);
        end
    endtask

    task automatic chk_all_zero(input string nm);
        for (int g = 0; g < 3; g++) begin
            chk(nm, int'({lvl[g], prs[g], rel[g], rpt[g], any[g]}), 0);
        end
    endtask

    // Counts clk edges from the current point until key_press[k] shows.
    task automatic measure(input int g, input int k, output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!prs[g][k] && lat < 200);
    endtask

    int lat, nr, nrel, nw;

    initial begin
        clr_n  = 1'b0;
        kin[0] = '0;
        kin[1] = '0;
        kin[2] = '1;
        repeat (3) @(negedge clk);
        chk_all_zero("reset_state");
        clr_n = 1'b1;
        repeat (20) @(negedge clk);

        // Clean press on cfg0 key 0.
        kin[0][0] = 1'b1;
        measure(0, 0, lat);
        chk_rng("press_latency", lat, 23, 32);
        chk("press_level", int'(lvl[0]), 1);

        // Glitch of 15 clk on cfg0 key 1.
        kin[0][1] = 1'b1;
        repeat (15) @(negedge clk);
        kin[0][1] = 1'b0;
        repeat (60) @(negedge clk);
        chk("glitch_level", int'(lvl[0][1]), 0);

        // Auto-repeat: hold cfg0 key 2 for 1500 clk.
        kin[0][2] = 1'b1;
        nr = 0;
        nrel = 0;
        repeat (1500) begin
            @(negedge clk);
            nr += int'(rpt[0][2]);
        end
        kin[0][2] = 1'b0;
        repeat (60) begin
            @(negedge clk);
            nr += int'(rpt[0][2]);
            nrel += int'(rel[0][2]);
        end
        chk("repeat_count", nr, 10);
        chk("release_count", nrel, 1);

        // Reset while cfg0 key 0 sits in auto-repeat.
        @(negedge clk);
        #2 clr_n = 1'b0;
        #1 chk_all_zero("async_reset");
        repeat (3) @(negedge clk);
        chk_all_zero("held_reset");
        clr_n = 1'b1;
        measure(0, 0, lat);
        chk("press_after_reset", lat, 30);

        // Simultaneous press on cfg1 with repeat disabled.
        @(negedge clk);
        kin[1][0] = 1'b1;
        kin[1][3] = 1'b1;
        nw = 0;
        while (prs[1] == '0 && nw < 100) begin
            @(negedge clk);
            nw++;
        end
        chk("simul_press", int'(prs[1]), 9);
        chk("simul_any", int'(any[1]), 1);
        nr = 0;
        repeat (800) begin
            @(negedge clk);
            nr += int'(rpt[1][0]) + int'(rpt[1][3]);
        end
        chk("no_repeat", nr, 0);
        kin[1] = '0;
        repeat (40) @(negedge clk);

        // Active-low input with a divider of 1 and single-sample accept.
        kin[2][0] = 1'b0;
        measure(2, 0, lat);
        chk("polarity_latency", lat, 3);
        chk("polarity_level", int'(lvl[2][0]), 1);
        repeat (20) @(negedge clk);
        kin[2][0] = 1'b1;
        repeat (10) @(negedge clk);

        // Random key activity on all configurations.
        repeat (4000) begin
            @(negedge clk);
            for (int g = 0; g < 3; g++) begin
                for (int k = 0; k < NK; k++) begin
                    if ($urandom_range(0, (g == 2) ? 12 : 60) == 0)
                        kin[g][k] = ~kin[g][k];
                end
            end
        end
        kin[0] = '0;
        kin[1] = '0;
        kin[2] = '1;
        repeat (200) @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            chk("final_level", int'(lvl[g]), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/key_debounce_multi.md
# key_debounce_multi

Multi-channel, parametrised key debouncer with edge-event and auto-repeat outputs. It sits between the raw board push-buttons and the waveform-generator control logic. Each key input is synchronised, then sampled on a shared divided tick enable, with no derived clock. A level change is accepted only after a configurable number of consecutive agreeing samples. Per key, the block emits a clean level, one-cycle press and release pulses, and optional auto-repeat pulses while the key is held.

## Interface
- N_KEYS, 4: number of independent key channels.
- CLK_DIV, 10: clk cycles per sample tick (≥1).
- STABLE_CNT, 3: consecutive disagreeing ticks needed to accept a change (≥1).
- REPEAT_DLY, 50: held ticks before the first repeat pulse; 0 disables repeat.
- REPEAT_RATE, 10: ticks between subsequent repeat pulses (≥1).
- ACTIVE_LOW_IN, 0: 1 inverts the raw inputs, for pressed = 0 buttons.

- clk  in  1  system clock; single clock domain.
- clr_n  in  1  asynchronous, active-low reset.
- key_in  in  N_KEYS  raw asynchronous key inputs.
- key_level  out  N_KEYS  debounced level; 1 = pressed.
- key_press  out  N_KEYS  one-clk pulse on accepted press.
- key_release  out  N_KEYS  one-clk pulse on accepted release.
- key_repeat  out  N_KEYS  one-clk pulse per auto-repeat event.
- key_any  out  1  OR of key_level.

## Operation
- **Reset:** while clr_n = 0, all outputs, synchronisers, counters and FSMs are 0 / RELEASED. Reset is asserted asynchronously; release is taken on a clk edge.
- **Input path:** key_in passes through a 2-FF synchroniser per bit, and is inverted first if ACTIVE_LOW_IN = 1.
- **Tick generator:**
  - A shared counter runs 0..CLK_DIV-1.
  - tick = 1 for one clk when the counter equals CLK_DIV-1.
  - CLK_DIV = 1 gives tick every cycle.
- **Per-channel debounce, on tick:**
  - If the synced sample equals key_level, stab_cnt <= 0.
  - Otherwise stab_cnt increments.
  - When the incremented value would equal STABLE_CNT, key_level toggles, stab_cnt <= 0, and press or release fires.
  - A single agreeing tick clears stab_cnt, so glitches shorter than STABLE_CNT ticks are rejected.
- **Per-channel repeat FSM (RELEASED, HELD, REPEAT):**
  - RELEASED -> HELD on accepted press; rep_cnt <= 0.
  - HELD: rep_cnt increments per tick. At REPEAT_DLY ticks, pulse key_repeat, rep_cnt <= 0, go to REPEAT. With REPEAT_DLY = 0, stay in HELD.
  - REPEAT: pulse key_repeat every REPEAT_RATE ticks.
  - HELD/REPEAT -> RELEASED on accepted release. No repeat pulse on the release tick; release has priority.
- **Counter widths:**
  - Tick counter: $clog2(CLK_DIV+1).
  - stab_cnt: $clog2(STABLE_CNT+1).
  - rep_cnt: $clog2(max(REPEAT_DLY, REPEAT_RATE)+1).
  - Counters never wrap: they are cleared on acceptance or pulse.
- **Independence:** channels are fully independent. Simultaneous events on different keys all pulse in the same cycle.

## Timing
- All outputs are registered and update on the same clk edge as the tick that causes them.
- Pulses last exactly one clk.
- Press latency from a key_in step to key_level = 1:
  - Minimum: 2 sync cycles, then the next tick, plus (STABLE_CNT-1)·CLK_DIV.
  - Defaults: between 2+20+1 and 2+30 clk.
- First tick after reset release is at clk edge CLK_DIV (counter starts at 0).
- key_press, key_release and key_repeat are mutually exclusive per channel per cycle.
- Defaults: first repeat 50 ticks (500 clk) after press acceptance, then every 100 clk.

## Structure
- Shared package key_pkg: the FSM state encoding (RELEASED = 2'd0, HELD = 2'd1, REPEAT = 2'd2) and the key polarity constant.
- Top-level key_debounce_multi holds the tick generator and the synchronisers.
- Sub-module key_channel holds one channel's stab_cnt, rep_cnt and FSM, and is instantiated N_KEYS times in a generate loop.

## Test plan
- **Clean press:** key_in[0] 0 -> 1 held, defaults. key_level[0] rises and key_press[0] pulses once, 23–32 clk after the step. No other channel toggles.
- **Glitch rejection:** a 15-clk high pulse on key_in[1]. key_level[1], key_press[1] and key_release[1] all stay 0.
- **Auto-repeat:** hold key_in[2] for 1500 clk.
  - key_repeat[2] fires 500 clk after key_press[2], then every 100 clk: 10 pulses total before release is accepted.
  - key_release[2] fires once; no repeat pulse in the same cycle.
- **Simultaneous and disabled repeat:** press keys 0 and 3 on the same clk with REPEAT_DLY = 0. Both key_press pulses appear in the same cycle, key_any = 1, and key_repeat never asserts.
- **Reset mid-operation:** assert clr_n = 0 while key 0 is in REPEAT. All outputs drop to 0 immediately. After release with key still high, key_press[0] fires again after the normal latency.
- **Polarity and divider:** ACTIVE_LOW_IN = 1, CLK_DIV = 1, STABLE_CNT = 1. key_in[0] 1 -> 0 gives key_level[0] = 1 and a key_press pulse 3 clk after the step.
